alu_ctrl_stage: RTL



---
 rtl/rv32_pkg.sv | 74 +++++++
 rtl/rv32_decode.sv | 141 ++++++++++++++
 rtl/alu_ctrl_stage.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32IM decode-to-execute control stage:
// ALU operation codes, base opcodes, the decoded control bundle and the
// output buffer state encoding.
package rv32_pkg;

  localparam int XLEN = 32;

  // ALU operation codes, matching the integer ALU encoding
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SLL    = 5'd1;
  localparam logic [4:0] ALU_SLT    = 5'd2;
  localparam logic [4:0] ALU_SLTU   = 5'd3;
  localparam logic [4:0] ALU_XOR    = 5'd4;
  localparam logic [4:0] ALU_SRL    = 5'd5;
  localparam logic [4:0] ALU_OR     = 5'd6;
  localparam logic [4:0] ALU_AND    = 5'd7;
  localparam logic [4:0] ALU_SUB    = 5'd8;
  localparam logic [4:0] ALU_SRA    = 5'd13;
  localparam logic [4:0] ALU_FWD    = 5'd16;
  localparam logic [4:0] ALU_MUL    = 5'd24;
  localparam logic [4:0] ALU_MULH   = 5'd25;
  localparam logic [4:0] ALU_MULHSU = 5'd26;
  localparam logic [4:0] ALU_MULHU  = 5'd27;
  localparam logic [4:0] ALU_DIV    = 5'd28;
  localparam logic [4:0] ALU_DIVU   = 5'd29;
  localparam logic [4:0] ALU_REM    = 5'd30;
  localparam logic [4:0] ALU_REMU   = 5'd31;

  // Base opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // funct7 values that carry meaning
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Decoded control bundle handed to the execute stage
  typedef struct packed {
    logic [4:0]      alu_op;
    logic            op1_sel;
    logic            op2_sel;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            illegal;
  } decoded_t;

  // One buffered entry: decoded controls plus the instruction address
  typedef struct packed {
    decoded_t        dec;
    logic [XLEN-1:0] pc;
  } entry_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/rv32_decode.sv
// Purely combinational RV32IM instruction decoder: instruction word in,
// decoded control bundle out. Register indices that the format does not
// use are reported as zero so downstream hazard logic never sees phantom
// dependencies. Shift-immediates report the shamt as the immediate.
module rv32_decode
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output decoded_t        dec
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_shamt;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign imm_i     = {{20{instr[31]}}, instr[31:20]};
  assign imm_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u     = {instr[31:12], 12'b0};
  assign imm_j     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_shamt = {27'b0, instr[24:20]};

  // Decode the instruction class, then squash side effects of illegal encodings
  always_comb begin
    logic bad;
    bad = 1'b0;
    dec = '0;
    case (opcode)
      OPC_OP: begin
        dec.rs1       = instr[19:15];
        dec.rs2       = instr[24:20];
        dec.rd        = instr[11:7];
        dec.reg_write = 1'b1;
        if (funct7 == F7_BASE) begin
          dec.alu_op = {2'b00, funct3};
        end else if (funct7 == F7_MULDIV) begin
          dec.alu_op = {2'b11, funct3};
        end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec.alu_op = {2'b01, funct3};
        end else begin
          bad = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec.rs1       = instr[19:15];
        dec.rd        = instr[11:7];
        dec.reg_write = 1'b1;
        dec.op2_sel   = 1'b1;
        dec.alu_op    = {2'b00, funct3};
        dec.imm       = imm_i;
        if (funct3 == 3'b001) begin
          dec.imm = imm_shamt;
          if (funct7 != F7_BASE) bad = 1'b1;
        end else if (funct3 == 3'b101) begin
          dec.imm = imm_shamt;
          if (funct7 == F7_ALT) dec.alu_op = ALU_SRA;
          else if (funct7 != F7_BASE) bad = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.rd        = instr[11:7];
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_FWD;
        dec.op2_sel   = 1'b1;
        dec.imm       = imm_u;
      end
      OPC_AUIPC: begin
        dec.rd        = instr[11:7];
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.op1_sel   = 1'b1;
        dec.op2_sel   = 1'b1;
        dec.imm       = imm_u;
      end
      OPC_JAL: begin
        dec.rd        = instr[11:7];
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.op1_sel   = 1'b1;
        dec.op2_sel   = 1'b1;
        dec.imm       = imm_j;
      end
      OPC_JALR: begin
        dec.rs1       = instr[19:15];
        dec.rd        = instr[11:7];
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.op2_sel   = 1'b1;
        dec.imm       = imm_i;
      end
      OPC_BRANCH: begin
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
        dec.imm    = imm_b;
      end
      OPC_LOAD: begin
        dec.rs1       = instr[19:15];
        dec.rd        = instr[11:7];
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.op2_sel   = 1'b1;
        dec.imm       = imm_i;
      end
      OPC_STORE: begin
        dec.rs1       = instr[19:15];
        dec.rs2       = instr[24:20];
        dec.mem_write = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.op2_sel   = 1'b1;
        dec.imm       = imm_s;
      end
      default: begin
        bad = 1'b1;
      end
    endcase
    if (bad) begin
      dec.alu_op    = ALU_ADD;
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
      dec.illegal   = 1'b1;
    end
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Decode-to-execute control stage. Instructions are decoded combinationally
// on the way in and captured into a two-entry skid buffer (main + skid).
// Every output, including IN_READY, comes straight from a register, so
// there is no combinational path from IN_* or OUT_READY to any output.
module alu_ctrl_stage
  import rv32_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [XLEN-1:0] IN_INSTR,
  input  logic [XLEN-1:0] IN_PC,
  input  logic            FLUSH,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [4:0]      ALU_OP,
  output logic            OP1_SEL,
  output logic            OP2_SEL,
  output logic [XLEN-1:0] IMM,
  output logic [4:0]      RS1,
  output logic [4:0]      RS2,
  output logic [4:0]      RD,
  output logic            REG_WRITE,
  output logic            MEM_READ,
  output logic            MEM_WRITE,
  output logic            BRANCH,
  output logic            JUMP,
  output logic            ILLEGAL,
  output logic [XLEN-1:0] OUT_PC
);

  decoded_t   dec_p0;
  entry_t     in_entry_p0;
  entry_t     main_p1;
  entry_t     skid_p1;
  buf_state_t state;
  logic       in_ready_q;
  logic       vld_p1;
  logic       acc;
  logic       take;

  rv32_decode u_decode (
    .instr (IN_INSTR),
    .dec   (dec_p0)
  );

  // ---- stage p0: decoded incoming instruction ----
  assign in_entry_p0 = '{dec: dec_p0, pc: IN_PC};
  assign acc         = IN_VALID & in_ready_q;
  assign take        = vld_p1 & OUT_READY;

  // Skid-buffer FSM; IN_READY and OUT_VALID are registered alongside state.
  // FLUSH outranks both handshakes, so an offer in the flush cycle is dropped.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= BUF_EMPTY;
      in_ready_q <= 1'b1;
      vld_p1     <= 1'b0;
      main_p1    <= '0;
      skid_p1    <= '0;
    end else if (FLUSH) begin
      state      <= BUF_EMPTY;
      in_ready_q <= 1'b1;
      vld_p1     <= 1'b0;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (acc) begin
            main_p1 <= in_entry_p0;
            vld_p1  <= 1'b1;
            state   <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (acc && take) begin
            main_p1 <= in_entry_p0;
          end else if (acc) begin
            skid_p1    <= in_entry_p0;
            in_ready_q <= 1'b0;
            state      <= BUF_TWO;
          end else if (take) begin
            vld_p1 <= 1'b0;
            state  <= BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          if (take) begin
            main_p1    <= skid_p1;
            in_ready_q <= 1'b1;
            state      <= BUF_ONE;
          end
        end
        default: begin
          vld_p1     <= 1'b0;
          in_ready_q <= 1'b1;
          state      <= BUF_EMPTY;
        end
      endcase
    end
  end

  // ---- stage p1: registered outputs from the main entry ----
  assign IN_READY  = in_ready_q;
  assign OUT_VALID = vld_p1;
  assign ALU_OP    = main_p1.dec.alu_op;
  assign OP1_SEL   = main_p1.dec.op1_sel;
  assign OP2_SEL   = main_p1.dec.op2_sel;
  assign IMM       = main_p1.dec.imm;
  assign RS1       = main_p1.dec.rs1;
  assign RS2       = main_p1.dec.rs2;
  assign RD        = main_p1.dec.rd;
  assign REG_WRITE = main_p1.dec.reg_write;
  assign MEM_READ  = main_p1.dec.mem_read;
  assign MEM_WRITE = main_p1.dec.mem_write;
  assign BRANCH    = main_p1.dec.branch;
  assign JUMP      = main_p1.dec.jump;
  assign ILLEGAL   = main_p1.dec.illegal;
  assign OUT_PC    = main_p1.pc;

endmodule
